// File: rtl/hazard_unit.sv
// hazard_unit: pipeline interlock, branch flush and operand-forward control; HAZARD_FORWARDING_EN enables forwarding.
// Latency: all controls combinational from ID inputs and the EX/MEM/WB records; records advance every cycle.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; flush overrides stall.
module hazard_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              id_ruwr,
    input  logic              id_load,
    input  logic              ex_branch_taken,
    input  logic              cnt_clr,
    output logic              stall,
    output logic              flush,
    output logic              ex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              id_fwd_rs1,
    output logic              id_fwd_rs2,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              use1;
        logic              use2;
    } ex_rec_t;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              wr;
        logic              ld;
    } stg_rec_t;

    ex_rec_t          ex_q, ex_d;
    stg_rec_t         mem_q, mem_d, wb_q, wb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic id_rd1, id_rd2, hazard;
    logic unused_rec;

    // x0 is hard-wired zero, so it never counts as a produced value.
    function automatic logic produces(input logic vld, input logic wr,
                                      input logic [REG_AW-1:0] rd,
                                      input logic [REG_AW-1:0] r);
        return vld & wr & (rd != '0) & (rd == r);
    endfunction

    always_comb begin
        id_rd1     = id_valid & id_use_rs1;
        id_rd2     = id_valid & id_use_rs2;
        flush      = ex_branch_taken & ex_q.vld;
        hazard     = 1'b0;
        fwd_a      = 2'b00;
        fwd_b      = 2'b00;
        id_fwd_rs1 = 1'b0;
        id_fwd_rs2 = 1'b0;
`ifdef HAZARD_FORWARDING_EN
        unused_rec = wb_q.ld;
        hazard = ex_q.ld &
                 ((id_rd1 & produces(ex_q.vld, ex_q.wr, ex_q.rd, id_rs1)) |
                  (id_rd2 & produces(ex_q.vld, ex_q.wr, ex_q.rd, id_rs2)));
        id_fwd_rs1 = id_rd1 & produces(wb_q.vld, wb_q.wr, wb_q.rd, id_rs1);
        id_fwd_rs2 = id_rd2 & produces(wb_q.vld, wb_q.wr, wb_q.rd, id_rs2);
        if (ex_q.vld & ex_q.use1) begin
            if (produces(mem_q.vld, mem_q.wr, mem_q.rd, ex_q.rs1))
                fwd_a = 2'b01;
            else if (produces(wb_q.vld, wb_q.wr, wb_q.rd, ex_q.rs1))
                fwd_a = 2'b10;
        end
        if (ex_q.vld & ex_q.use2) begin
            if (produces(mem_q.vld, mem_q.wr, mem_q.rd, ex_q.rs2))
                fwd_b = 2'b01;
            else if (produces(wb_q.vld, wb_q.wr, wb_q.rd, ex_q.rs2))
                fwd_b = 2'b10;
        end
`else
        unused_rec = ^{wb_q.ld, ex_q.rs1, ex_q.rs2, ex_q.use1, ex_q.use2};
        // Without bypass paths the consumer waits until the producer has retired.
        hazard = (id_rd1 & (produces(ex_q.vld, ex_q.wr, ex_q.rd, id_rs1) |
                            produces(mem_q.vld, mem_q.wr, mem_q.rd, id_rs1) |
                            produces(wb_q.vld, wb_q.wr, wb_q.rd, id_rs1))) |
                 (id_rd2 & (produces(ex_q.vld, ex_q.wr, ex_q.rd, id_rs2) |
                            produces(mem_q.vld, mem_q.wr, mem_q.rd, id_rs2) |
                            produces(wb_q.vld, wb_q.wr, wb_q.rd, id_rs2)));
`endif
        stall     = hazard & ~flush;
        ex_bubble = stall | flush;
    end

    always_comb begin
        ex_d = '0;
        if (id_valid & ~ex_bubble) begin
            ex_d.vld  = 1'b1;
            ex_d.rd   = id_rd;
            ex_d.wr   = id_ruwr;
            ex_d.ld   = id_load;
            ex_d.rs1  = id_rs1;
            ex_d.rs2  = id_rs2;
            ex_d.use1 = id_use_rs1;
            ex_d.use2 = id_use_rs2;
        end
        mem_d.vld = ex_q.vld;
        mem_d.rd  = ex_q.rd;
        mem_d.wr  = ex_q.wr;
        mem_d.ld  = ex_q.ld;
        wb_d      = mem_q;

        cnt_d = cnt_q;
        if (cnt_clr)
            cnt_d = '0;
        else if (stall && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed pipeline scenarios plus randomized traffic against an instruction-level model.
// A second instance with a 2-bit stall counter shares all inputs to exercise saturation.
module tb_hazard_unit;

`ifdef HAZARD_FORWARDING_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid, id_use_rs1, id_use_rs2, id_ruwr, id_load;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken, cnt_clr;

    logic        stall, flush, ex_bubble, id_fwd_rs1, id_fwd_rs2;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic        s2_stall, s2_flush, s2_ex_bubble, s2_id_fwd_rs1, s2_id_fwd_rs2;
    logic [1:0]  s2_fwd_a, s2_fwd_b;
    logic [1:0]  s2_stall_cnt;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(5), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ruwr(id_ruwr), .id_load(id_load),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .stall(stall), .flush(flush), .ex_bubble(ex_bubble),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .id_fwd_rs1(id_fwd_rs1), .id_fwd_rs2(id_fwd_rs2),
        .stall_cnt(stall_cnt)
    );

    hazard_unit #(.REG_AW(5), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_ruwr(id_ruwr), .id_load(id_load),
        .ex_branch_taken(ex_branch_taken), .cnt_clr(cnt_clr),
        .stall(s2_stall), .flush(s2_flush), .ex_bubble(s2_ex_bubble),
        .fwd_a(s2_fwd_a), .fwd_b(s2_fwd_b),
        .id_fwd_rs1(s2_id_fwd_rs1), .id_fwd_rs2(s2_id_fwd_rs2),
        .stall_cnt(s2_stall_cnt)
    );

    // Instruction-level model: pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB.
    typedef struct {
        bit v; int rd; bit wr; bit ld; int rs1; int rs2; bit u1; bit u2;
    } instr_t;

    instr_t pipe[3];
    int     m_cnt, m_cnt2;
    bit     e_stall, e_flush, e_bub, e_if1, e_if2;
    bit [1:0] e_fa, e_fb;
    logic [8:0] obs, obs2, exp_v;
    int     cnt_obs, cnt2_obs, exp_cnt, exp_cnt2;
    int     tests = 0, fails = 0;

    function automatic bit prod(instr_t s, int r);
        return s.v && s.wr && (s.rd != 0) && (s.rd == r);
    endfunction

    function automatic bit [1:0] fsel(bit uses, int r);
        if (!pipe[0].v || !uses) return 2'd0;
        if (prod(pipe[1], r)) return 2'd1;
        if (prod(pipe[2], r)) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) pipe[k] = '{default: 0};
        m_cnt = 0;
        m_cnt2 = 0;
    endtask

    task automatic model_eval();
        bit need1 = id_valid && id_use_rs1;
        bit need2 = id_valid && id_use_rs2;
        bit hz = 1'b0;
        e_flush = ex_branch_taken && pipe[0].v;
        e_fa = 2'd0; e_fb = 2'd0; e_if1 = 1'b0; e_if2 = 1'b0;
        if (FWD) begin
            hz = pipe[0].ld && ((need1 && prod(pipe[0], int'(id_rs1))) ||
                                (need2 && prod(pipe[0], int'(id_rs2))));
            e_fa  = fsel(pipe[0].u1, pipe[0].rs1);
            e_fb  = fsel(pipe[0].u2, pipe[0].rs2);
            e_if1 = need1 && prod(pipe[2], int'(id_rs1));
            e_if2 = need2 && prod(pipe[2], int'(id_rs2));
        end else begin
            for (int k = 0; k < 3; k++)
                if ((need1 && prod(pipe[k], int'(id_rs1))) || (need2 && prod(pipe[k], int'(id_rs2))))
                    hz = 1'b1;
        end
        e_stall = hz && !e_flush;
        e_bub   = e_stall || e_flush;
    endtask

    task automatic model_clock();
        if (cnt_clr) begin
            m_cnt = 0; m_cnt2 = 0;
        end else if (e_stall) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = '{default: 0};
        if (id_valid && !e_bub) begin
            pipe[0].v = 1'b1; pipe[0].rd = int'(id_rd); pipe[0].wr = id_ruwr;
            pipe[0].ld = id_load; pipe[0].rs1 = int'(id_rs1); pipe[0].rs2 = int'(id_rs2);
            pipe[0].u1 = id_use_rs1; pipe[0].u2 = id_use_rs2;
        end
    endtask

    task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                          input bit u1, input bit u2, input bit wr, input bit ld);
        id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_rd = 5'(rd);
        id_use_rs1 = u1; id_use_rs2 = u2; id_ruwr = wr; id_load = ld;
    endtask

    // One cycle: sample both DUTs mid-cycle, then advance the model on the edge.
    task automatic tick();
        @(negedge clk);
        model_eval();
        obs   = {stall, flush, ex_bubble, fwd_a, fwd_b, id_fwd_rs1, id_fwd_rs2};
        obs2  = {s2_stall, s2_flush, s2_ex_bubble, s2_fwd_a, s2_fwd_b, s2_id_fwd_rs1, s2_id_fwd_rs2};
        exp_v = {e_stall, e_flush, e_bub, e_fa, e_fb, e_if1, e_if2};
        cnt_obs = int'(stall_cnt); cnt2_obs = int'(s2_stall_cnt);
        exp_cnt = m_cnt; exp_cnt2 = m_cnt2;
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 1'b0; cnt_clr = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_id(1, 3, 4, 5, 1, 1, 1, 1);
        ex_branch_taken = 1'b1; cnt_clr = 1'b0;
        #2;
        tests++;
        if ({stall, flush, ex_bubble, fwd_a, fwd_b, id_fwd_rs1, id_fwd_rs2} !== 9'd0) begin
            fails++; $display("FAIL reset_outputs: got %b want 0", {stall, flush, ex_bubble, fwd_a, fwd_b, id_fwd_rs1, id_fwd_rs2});
        end
        @(posedge clk); @(negedge clk);
        tests++;
        if (stall_cnt !== 16'd0 || s2_stall_cnt !== 2'd0) begin
            fails++; $display("FAIL reset_cnt: got %0d/%0d want 0", stall_cnt, s2_stall_cnt);
        end
        tests++;
        if (s2_ex_bubble !== 1'b0 || flush !== 1'b0) begin
            fails++; $display("FAIL reset_held: got bubble=%b flush=%b want 0", s2_ex_bubble, flush);
        end
        do_reset();
    endtask

    task automatic test_fwd_alu();
        int nst = 0;
        do_reset();
        set_id(1, 1, 2, 5, 1, 1, 1, 0);
        tick();
        tests++;
        if (obs !== exp_v) begin fails++; $display("FAIL alu_producer: got %b want %b", obs, exp_v); end
        set_id(1, 5, 1, 6, 1, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL alu_consumer_id: got %b want %b", obs, exp_v); end
            if (obs[8]) nst++;
            if (!e_stall) break;
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (nst !== (FWD ? 0 : 3)) begin fails++; $display("FAIL alu_stall_cycles: got %0d want %0d", nst, FWD ? 0 : 3); end
        tests++;
        if (obs[5:4] !== (FWD ? 2'b01 : 2'b00) || obs[8] !== 1'b0) begin
            fails++; $display("FAIL alu_fwd_a: got fwd_a=%b stall=%b want %b/0", obs[5:4], obs[8], FWD ? 2'b01 : 2'b00);
        end
    endtask

    task automatic test_load_use();
        int nst = 0;
        do_reset();
        set_id(1, 2, 0, 7, 1, 0, 1, 1);
        tick();
        set_id(1, 7, 7, 8, 1, 1, 1, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (obs !== exp_v) begin fails++; $display("FAIL load_use_id: got %b want %b", obs, exp_v); end
            if (obs[8]) nst++;
            if (!e_stall) break;
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (nst !== (FWD ? 1 : 3)) begin fails++; $display("FAIL load_use_stalls: got %0d want %0d", nst, FWD ? 1 : 3); end
        tests++;
        if (obs[5:2] !== (FWD ? 4'b1010 : 4'b0000)) begin
            fails++; $display("FAIL load_use_fwd: got %b want %b", obs[5:2], FWD ? 4'b1010 : 4'b0000);
        end
        tests++;
        if (cnt_obs !== (FWD ? 1 : 3)) begin fails++; $display("FAIL load_use_cnt: got %0d want %0d", cnt_obs, FWD ? 1 : 3); end
    endtask

    task automatic test_wb_fwd();
        do_reset();
        set_id(1, 1, 2, 9, 1, 1, 1, 0);
        tick();
        set_id(1, 3, 4, 10, 1, 1, 1, 0);
        tick();
        set_id(1, 9, 0, 11, 1, 0, 1, 0);
        tick();
        tests++;
        if (obs[1] !== FWD || obs[8] !== !FWD) begin
            fails++; $display("FAIL wb_id_fwd: got id_fwd_rs1=%b stall=%b want %b/%b", obs[1], obs[8], FWD, !FWD);
        end
        for (int i = 0; i < 6 && e_stall; i++) tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (obs[5:4] !== 2'b00 || obs !== exp_v) begin fails++; $display("FAIL wb_retired_fwd_a: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1, 2, 0, 7, 1, 0, 1, 1);
        tick();
        set_id(1, 7, 0, 8, 1, 0, 1, 0);
        ex_branch_taken = 1'b1;
        tick();
        tests++;
        if (obs[8:6] !== 3'b011) begin fails++; $display("FAIL flush_priority: got %b want 011", obs[8:6]); end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (obs[7] !== 1'b0) begin fails++; $display("FAIL flush_ex_invalid: got flush=%b want 0", obs[7]); end
        ex_branch_taken = 1'b0;
    endtask

    task automatic test_x0();
        do_reset();
        set_id(1, 1, 2, 0, 1, 1, 1, 1);
        tick();
        set_id(1, 0, 0, 0, 1, 1, 1, 0);
        tick();
        tests++;
        if (obs[8] !== 1'b0) begin fails++; $display("FAIL x0_no_stall: got %b want 0", obs[8]); end
        set_id(1, 0, 0, 3, 1, 1, 1, 0);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (obs !== 9'd0) begin fails++; $display("FAIL x0_no_fwd: got %b want 0", obs); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int p = 0; p < 5; p++) begin
            set_id(1, 2, 0, 7, 1, 0, 1, 1);
            tick();
            set_id(1, 7, 0, 8, 1, 0, 1, 0);
            for (int i = 0; i < 6; i++) begin
                tick();
                if (!e_stall) break;
            end
        end
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (cnt2_obs !== 3) begin fails++; $display("FAIL sat_cnt2: got %0d want 3", cnt2_obs); end
        tests++;
        if (cnt_obs !== (FWD ? 5 : 15)) begin fails++; $display("FAIL sat_cnt16: got %0d want %0d", cnt_obs, FWD ? 5 : 15); end
        // Reset lands while a load-use stall is being presented.
        set_id(1, 2, 0, 7, 1, 0, 1, 1);
        tick();
        set_id(1, 7, 0, 8, 1, 0, 1, 0);
        @(negedge clk);
        tests++;
        if (stall !== 1'b1) begin fails++; $display("FAIL midstall_pre: got stall=%b want 1", stall); end
        #1 rst_n = 1'b0;
        #1;
        tests++;
        if ({stall, flush, ex_bubble, fwd_a, fwd_b, id_fwd_rs1, id_fwd_rs2, stall_cnt, s2_stall_cnt} !== 27'd0) begin
            fails++; $display("FAIL midstall_async: got %b cnt=%0d/%0d want 0", {stall, flush, ex_bubble, fwd_a, fwd_b, id_fwd_rs1, id_fwd_rs2}, stall_cnt, s2_stall_cnt);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        tick();
        tests++;
        if (obs[8] !== 1'b0 || obs !== exp_v) begin fails++; $display("FAIL post_reset_stall: got %b want %b", obs, exp_v); end
        // Clear coinciding with a stall must win over the increment.
        set_id(1, 2, 0, 7, 1, 0, 1, 1);
        tick();
        set_id(1, 7, 0, 8, 1, 0, 1, 0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        for (int i = 0; i < 6 && e_stall; i++) tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (cnt_obs !== (FWD ? 0 : 2) || cnt2_obs !== (FWD ? 0 : 2)) begin
            fails++; $display("FAIL clr_priority: got %0d/%0d want %0d", cnt_obs, cnt2_obs, FWD ? 0 : 2);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_id($urandom_range(7, 0) != 0, $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0),
                   $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0);
            ex_branch_taken = ($urandom_range(5, 0) == 0);
            cnt_clr = ($urandom_range(29, 0) == 0);
            tick();
            tests++;
            if (obs !== exp_v || obs2 !== exp_v || cnt_obs !== exp_cnt || cnt2_obs !== exp_cnt2) begin
                fails++;
                if (bad++ < 10)
                    $display("FAIL random_c%0d: got %b/%b cnt=%0d/%0d want %b cnt=%0d/%0d",
                             c, obs, obs2, cnt_obs, cnt2_obs, exp_v, exp_cnt, exp_cnt2);
            end
        end
        ex_branch_taken = 1'b0;
        cnt_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 1'b0;
        cnt_clr = 1'b0;
        model_reset();
        test_reset();
        test_fwd_alu();
        test_load_use();
        test_wb_fwd();
        test_flush();
        test_x0();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
